// File: rtl/ppu_render_sequencer.sv
// Frame/scanline scheduler for the VRAM load FSM: walks the visible screen in tile-wide
// segments with fine-X scroll, and produces vblank timing, NMI and sprite-0 status.
module ppu_render_sequencer #(
    parameter int SCREEN_ROWS   = 240,
    parameter int SCREEN_COLS   = 256,
    parameter int SEG_W         = 8,
    parameter int VBLANK_CYCLES = 2273,
    parameter int BUSY_TIMEOUT  = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] ppu_ctrl1,
    input  logic [7:0] ppu_ctrl2,
    input  logic [2:0] fine_x,
    input  logic       fsm_busy,
    input  logic       sprite_0_hit,
    input  logic       status_rd,
    output logic       fsm_start,
    output logic [8:0] curr_row,
    output logic [8:0] curr_col,
    output logic       vblank,
    output logic       vblank_flag,
    output logic       nmi,
    output logic       sprite0_flag,
    output logic       timeout_err,
    output logic       frame_done
);
    localparam int WAIT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int VB_W   = $clog2(VBLANK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_START,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_NEXT,
        S_VBLANK
    } state_t;

    state_t            state_reg, state_next;
    logic [8:0]        row_reg, col_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [VB_W-1:0]   vb_cnt_reg;
    logic              vblank_flag_reg, nmi_reg, sprite0_reg, timeout_reg, frame_done_reg;

    logic       render_en, wait_expired, vb_last, col_in_row, row_last;
    logic [9:0] col_sum;
    logic [8:0] row_sum;
    logic       ctrl_unused;

    assign render_en    = |ppu_ctrl2[4:3];
    // One extra bit so that 248 + 8 compares as 256 instead of wrapping negative.
    assign col_sum      = {col_reg[8], col_reg} + 10'(SEG_W);
    assign col_in_row   = $signed(col_sum) < $signed(10'(SCREEN_COLS));
    assign row_sum      = row_reg + 9'd1;
    assign row_last     = (row_sum == 9'(SCREEN_ROWS));
    assign wait_expired = (wait_cnt_reg == WAIT_W'(BUSY_TIMEOUT - 1));
    assign vb_last      = (vb_cnt_reg == VB_W'(VBLANK_CYCLES - 1));
    assign ctrl_unused  = ^{ppu_ctrl1[6:0], ppu_ctrl2[7:5], ppu_ctrl2[2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fsm_start  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_ROW_START;
            end
            S_ROW_START: state_next = S_ISSUE;
            S_ISSUE: begin
                if (render_en) begin
                    fsm_start  = 1'b1;
                    state_next = S_GUARD;
                end else begin
                    state_next = S_NEXT;
                end
            end
            // The load FSM raises busy one cycle after start, so skip that cycle.
            S_GUARD: state_next = S_WAIT;
            S_WAIT: begin
                if (!fsm_busy || wait_expired) state_next = S_NEXT;
            end
            S_NEXT: begin
                if (!run)            state_next = S_IDLE;
                else if (col_in_row) state_next = S_ISSUE;
                else if (row_last)   state_next = S_VBLANK;
                else                 state_next = S_ROW_START;
            end
            S_VBLANK: begin
                if (vb_last) state_next = run ? S_ROW_START : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_reg         <= '0;
            col_reg         <= '0;
            wait_cnt_reg    <= '0;
            vb_cnt_reg      <= '0;
            vblank_flag_reg <= 1'b0;
            nmi_reg         <= 1'b0;
            sprite0_reg     <= 1'b0;
            timeout_reg     <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            nmi_reg        <= vblank_flag_reg & ppu_ctrl1[7];
            // Placed before the state case so a same-cycle vblank entry overrides the clear.
            if (status_rd) vblank_flag_reg <= 1'b0;
            if ((state_reg == S_GUARD || state_reg == S_WAIT) && sprite_0_hit)
                sprite0_reg <= 1'b1;
            case (state_reg)
                S_ROW_START: col_reg <= 9'd0 - 9'(fine_x);
                S_GUARD:     wait_cnt_reg <= '0;
                S_WAIT: begin
                    if (fsm_busy) begin
                        if (wait_expired) timeout_reg <= 1'b1;
                        else              wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (run) begin
                        col_reg <= col_sum[8:0];
                        if (!col_in_row) begin
                            row_reg <= row_sum;
                            if (row_last) begin
                                frame_done_reg  <= 1'b1;
                                vblank_flag_reg <= 1'b1;
                                vb_cnt_reg      <= '0;
                            end
                        end
                    end
                end
                S_VBLANK: begin
                    vb_cnt_reg <= vb_cnt_reg + VB_W'(1);
                    if (vb_last) begin
                        row_reg         <= '0;
                        vblank_flag_reg <= 1'b0;
                        sprite0_reg     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign curr_row     = row_reg;
    assign curr_col     = col_reg;
    assign vblank       = (state_reg == S_VBLANK);
    assign vblank_flag  = vblank_flag_reg;
    assign nmi          = nmi_reg;
    assign sprite0_flag = sprite0_reg;
    assign timeout_err  = timeout_reg;
    assign frame_done   = frame_done_reg;

endmodule
